// File: rtl/if_stage_if.sv
// Instruction-fetch bundle: ROM request/response, execute-stage redirect
// and the valid/ready output towards decode.
interface if_stage_if;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_gnt;
  logic        irom_rvalid;
  logic [31:0] irom_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  // Fetch stage side
  modport master (
    output irom_req, irom_addr,
    input  irom_gnt, irom_rvalid, irom_rdata,
    input  redirect, redirect_pc,
    input  id_ready,
    output id_valid, id_inst, id_pc, id_pc4
  );

  // ROM / execute / decode side
  modport slave (
    input  irom_req, irom_addr,
    output irom_gnt, irom_rvalid, irom_rdata,
    output redirect, redirect_pc,
    output id_ready,
    input  id_valid, id_inst, id_pc, id_pc4
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from the
// instruction ROM and hands {inst, pc, pc+4} to decode through a single
// valid/ready output register. Redirects from execute flush everything.
//
// state  | meaning
// S_REQ  | request pc when the output slot is free, wait for gnt
// S_WAIT | request accepted, waiting for rvalid (data dropped if kill set)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       id_pc_q, id_pc_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              req;
  logic              load;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Next-state, fetch request and output-register update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    pc4_d   = pc4_q;
    load    = 1'b0;
    // Only fetch when the output slot is free or being drained this cycle,
    // so a returning word always has somewhere to land.
    req     = (state_q == S_REQ) && (!valid_q || bus.id_ready) && !rst;

    case (state_q)
      S_REQ: begin
        if (req && bus.irom_gnt) begin
          state_d = S_WAIT;
          // A redirect in the grant cycle means this response is stale.
          kill_d  = bus.redirect;
        end
      end
      S_WAIT: begin
        if (bus.irom_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          load    = !kill_q && !bus.redirect;
        end else if (bus.redirect) begin
          kill_d  = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (valid_q && bus.id_ready) valid_d = 1'b0;

    if (load) begin
      valid_d = 1'b1;
      inst_d  = bus.irom_rdata;
      id_pc_d = pc_q;
      pc4_d   = pc_plus4;
      pc_d    = pc_plus4;
    end

    // Redirect wins over the sequential pc+4 and flushes the output slot.
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & ~32'h3;
      valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= NOP;
      id_pc_q <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign bus.irom_req  = req;
  assign bus.irom_addr = pc_q;
  assign bus.id_valid  = valid_q;
  assign bus.id_inst   = inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural ROM whose grant and
// read latency are controlled per test. ROM word = addr ^ 32'h1357_9BDF.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ROM model: grant follows gnt_en, rvalid arrives rom_lat cycles after
  // the grant. Deliberately not reset by rst so a stray rvalid can follow it.
  logic        gnt_en  = 1'b1;
  int          rom_lat = 1;
  logic        rom_pend = 1'b0;
  int          rom_cnt  = 0;
  logic [31:0] rom_addr = 32'h0;

  assign bus.irom_gnt    = bus.irom_req && gnt_en;
  assign bus.irom_rvalid = rom_pend && (rom_cnt == 0);
  assign bus.irom_rdata  = bus.irom_rvalid ? (rom_addr ^ 32'h1357_9BDF) : 32'h0;

  // ROM response timing
  always @(posedge clk) begin
    if (bus.irom_rvalid) rom_pend <= 1'b0;
    else if (rom_pend) rom_cnt <= rom_cnt - 1;
    if (bus.irom_req && bus.irom_gnt) begin
      rom_pend <= 1'b1;
      rom_addr <= bus.irom_addr;
      rom_cnt  <= rom_lat - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(bus.id_valid), 32'd0);
    chk({tag, "_inst"},  bus.id_inst, 32'h0000_0013);
    chk({tag, "_pc"},    bus.id_pc,   32'h0000_0000);
    chk({tag, "_pc4"},   bus.id_pc4,  32'h0000_0004);
    chk({tag, "_req"},   32'(bus.irom_req), 32'd0);
    chk({tag, "_addr"},  bus.irom_addr, 32'h0000_0000);
  endtask

  // Holds reset long enough for any outstanding ROM response to drain,
  // then releases it; returns #1 after the first post-reset edge (C0).
  task automatic do_reset();
    rst             = 1'b1;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    gnt_en          = 1'b1;
    rom_lat         = 1;
    repeat (4) @(posedge clk);
    mid();
    chk_reset_vals("rst");
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Streaming with a zero-wait ROM
    do_reset();
    mid();
    chk("s_addr0", bus.irom_addr, 32'h0);
    chk("s_req0",  32'(bus.irom_req), 32'd1);
    nxt(); mid();
    chk("s_req_wait", 32'(bus.irom_req), 32'd0);
    chk("s_valid_c1", 32'(bus.id_valid), 32'd0);
    nxt(); mid();
    chk("s_valid_c2", 32'(bus.id_valid), 32'd1);
    chk("s_pc0",   bus.id_pc,   32'h0);
    chk("s_inst0", bus.id_inst, 32'h1357_9BDF);
    chk("s_pc4_0", bus.id_pc4,  32'h4);
    chk("s_addr4", bus.irom_addr, 32'h4);
    chk("s_req4",  32'(bus.irom_req), 32'd1);
    nxt(); mid();
    chk("s_valid_c3", 32'(bus.id_valid), 32'd0);
    nxt(); mid();
    chk("s_pc4",   bus.id_pc,   32'h4);
    chk("s_inst4", bus.id_inst, 32'h1357_9BDB);
    chk("s_addr8", bus.irom_addr, 32'h8);
    nxt(); nxt(); mid();
    chk("s_pc8",   bus.id_pc,   32'h8);
    chk("s_inst8", bus.id_inst, 32'h1357_9BD7);
    chk("s_pc4_8", bus.id_pc4,  32'hC);

    // Back-pressure from decode
    do_reset();
    bus.id_ready = 1'b0;
    nxt(); nxt();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      mid();
      chk("bp_valid", 32'(bus.id_valid), 32'd1);
      chk("bp_pc",    bus.id_pc,   32'h0);
      chk("bp_inst",  bus.id_inst, 32'h1357_9BDF);
      chk("bp_req",   32'(bus.irom_req), 32'd0);
    end
    nxt();
    bus.id_ready = 1'b1;
    mid();
    chk("bp_req_rel",  32'(bus.irom_req), 32'd1);
    chk("bp_addr_rel", bus.irom_addr, 32'h4);
    nxt(); mid();
    chk("bp_drained", 32'(bus.id_valid), 32'd0);

    // Redirect while waiting on a slow response
    do_reset();
    rom_lat = 3;
    mid();
    chk("rw_addr0", bus.irom_addr, 32'h0);
    nxt();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    mid();
    chk("rw_req_wait", 32'(bus.irom_req), 32'd0);
    nxt();
    bus.redirect = 1'b0;
    mid();
    chk("rw_addr_new", bus.irom_addr, 32'h100);
    chk("rw_req_c2",   32'(bus.irom_req), 32'd0);
    nxt();
    rom_lat = 1;
    mid();
    chk("rw_valid_c3", 32'(bus.id_valid), 32'd0);
    nxt(); mid();
    chk("rw_dropped", 32'(bus.id_valid), 32'd0);
    chk("rw_req",     32'(bus.irom_req), 32'd1);
    chk("rw_addr",    bus.irom_addr, 32'h100);
    nxt(); nxt(); mid();
    chk("rw_valid", 32'(bus.id_valid), 32'd1);
    chk("rw_pc",    bus.id_pc,   32'h100);
    chk("rw_inst",  bus.id_inst, 32'h1357_9ADF);

    // Redirect coinciding with the grant for addr 8
    do_reset();
    nxt(); nxt(); nxt(); nxt();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    mid();
    chk("rg_addr8", bus.irom_addr, 32'h8);
    chk("rg_req8",  32'(bus.irom_req), 32'd1);
    nxt();
    bus.redirect = 1'b0;
    mid();
    chk("rg_flush", 32'(bus.id_valid), 32'd0);
    chk("rg_addr",  bus.irom_addr, 32'h200);
    chk("rg_req_w", 32'(bus.irom_req), 32'd0);
    nxt(); mid();
    chk("rg_dropped", 32'(bus.id_valid), 32'd0);
    chk("rg_req",     32'(bus.irom_req), 32'd1);
    nxt(); nxt(); mid();
    chk("rg_valid", 32'(bus.id_valid), 32'd1);
    chk("rg_pc",    bus.id_pc,   32'h200);
    chk("rg_inst",  bus.id_inst, 32'h1357_99DF);
    chk("rg_pc4",   bus.id_pc4,  32'h204);

    // PC wrap, then asynchronous reset mid-fetch with a stray rvalid
    do_reset();
    gnt_en          = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    mid();
    chk("wr_req_nognt", 32'(bus.irom_req), 32'd1);
    nxt();
    bus.redirect = 1'b0;
    gnt_en       = 1'b1;
    mid();
    chk("wr_addr_top", bus.irom_addr, 32'hFFFF_FFFC);
    nxt(); nxt();
    rom_lat = 3;
    mid();
    chk("wr_pc",   bus.id_pc,   32'hFFFF_FFFC);
    chk("wr_pc4",  bus.id_pc4,  32'h0);
    chk("wr_inst", bus.id_inst, 32'hECA8_6423);
    chk("wr_addr", bus.irom_addr, 32'h0);
    nxt();
    rst = 1'b1;
    mid();
    chk_reset_vals("ar");
    nxt();
    rst    = 1'b0;
    gnt_en = 1'b0;
    mid();
    chk("ar_req_after", 32'(bus.irom_req), 32'd1);
    nxt(); mid();
    chk("ar_stray_c6", 32'(bus.id_valid), 32'd0);
    nxt(); mid();
    chk("ar_stray_c7", 32'(bus.id_valid), 32'd0);
    nxt();
    gnt_en  = 1'b1;
    rom_lat = 1;
    nxt(); nxt(); mid();
    chk("ar_valid", 32'(bus.id_valid), 32'd1);
    chk("ar_pc",    bus.id_pc,   32'h0);
    chk("ar_inst",  bus.id_inst, 32'h1357_9BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
